icw_ocw_sequencer: RTL and testbench
====================================

// Module: icw_ocw_sequencer
// PURPOSE
// Downstream of the read/write logic. Consumes CPU write cycles (chip_select_bar, write_bar, A0,
// internal_bus) and runs the ICW1..ICW4 initialization sequence. Latches the init and operation
// command words, then drives the held mode registers and command pulses used by the priority
// resolver and the interrupt-mask / in-service logic.
// PARAMETERS
// IMR_RESET_VAL  8'h00  value loaded into imr by reset_bar (ICW1 always clears imr to 8'h00)
// ICW4_NONE_VAL  8'h00  value loaded into icw4_reg when ICW1 has IC4=0
// PORTS
// clk              in   1  system clock, all state on rising edge
// reset_bar        in   1  reset, asynchronous, active-low
// chip_select_bar  in   1  device select, active-low
// write_bar        in   1  CPU write strobe, active-low, synchronous to clk
// A0               in   1  command-word address bit
// internal_bus     in   8  write data from read/write logic
// icw1_reg         out  8  last ICW1 (D0 IC4, D1 SNGL, D3 LTIM)
// icw2_reg         out  8  vector base, [7:3] used
// icw3_reg         out  8  cascade master/slave word
// icw4_reg         out  8  ICW4 (D1 AEOI, D0 uPM)
// imr              out  8  interrupt mask (OCW1)
// ocw2_cmd         out  8  last OCW2 byte (R,SL,EOI,L2..L0)
// ocw2_valid       out  1  one-clk pulse, ocw2_cmd just updated
// poll_cmd         out  1  one-clk pulse, OCW3 with P=1
// read_select      out  2  {RR,RIS}: 2'b10 = IRR, 2'b11 = ISR
// special_mask     out  1  special mask mode (OCW3 ESMM/SMM)
// init_done        out  1  1 only in READY
// init_state       out  3  FSM state code (debug)
// BEHAVIOUR
// Write capture: wr_active = ~chip_select_bar & ~write_bar, sampled every clk into wr_q.
//  - each clk with wr_active=1: wdata <= internal_bus, wa0 <= A0 (last sampled value wins).
//  - commit edge = first clk where wr_q=1 and wr_active=0. Decode of {wa0,wdata} happens on this edge.
//  - outputs are valid after the commit edge: 1 clk after write_bar (or chip_select_bar) is first sampled high.
//  - consecutive writes need >=1 clk sample with wr_active=0 between them; otherwise they merge into one
//    write and the last data wins. chip_select_bar rising mid-write also commits.
// FSM states: UNINIT=0, WAIT_ICW2=1, WAIT_ICW3=2, WAIT_ICW4=3, READY=4. Codes 5..7 recover to UNINIT.
//  - ICW1 (wa0=0, wdata[4]=1), accepted in ANY state, restarts the sequence:
//    icw1_reg<=wdata; imr<=0; special_mask<=0; read_select<=2'b10; icw4_reg<=ICW4_NONE_VAL if wdata[0]=0;
//    -> WAIT_ICW2. icw2/icw3 hold their old values until rewritten.
//  - WAIT_ICW2: wa0=1 -> icw2_reg. Next state: WAIT_ICW3 if icw1[1]=0; else WAIT_ICW4 if icw1[0]=1; else READY.
//  - WAIT_ICW3: wa0=1 -> icw3_reg. Next state: WAIT_ICW4 if icw1[0]=1, else READY.
//  - WAIT_ICW4: wa0=1 -> icw4_reg. Next state: READY.
//  - While in any WAIT_* state, wa0=0 writes that are not ICW1 are ignored.
//  - UNINIT: every write except ICW1 is ignored.
//  - READY:
//    wa0=1 -> imr<=wdata.
//    wa0=0, D4=0, D3=0 (OCW2): ocw2_cmd<=wdata; ocw2_valid=1 for exactly 1 clk.
//    wa0=0, D4=0, D3=1 (OCW3): if D1=1, read_select<={1,D0}; if D6=1, special_mask<=D5;
//      if D2=1, poll_cmd=1 for exactly 1 clk. Bits with enable=0 leave their field unchanged.
// Reset (async, any time, including mid-sequence or mid-write): state=UNINIT.
//  All regs 0 except imr=IMR_RESET_VAL and read_select=2'b10. Pulses=0; wr_q=0; wdata/wa0=0.
//  A write that is still active when reset releases commits normally when it ends.
// ocw2_valid and poll_cmd never assert outside READY and never assert on the same clk.
// TESTING
// T1 reset: reset_bar=0 -> init_state=0, imr=IMR_RESET_VAL, read_select=2'b10, init_done=0, pulses 0.
// T2 single, no ICW4: write A0=0 8'h12, then A0=1 8'h40 -> icw1=12, icw2=40, icw4=00, READY, init_done=1.
// T3 cascade + ICW4: A0=0 8'h11, A0=1 8'h08, A0=1 8'h04, A0=1 8'h03 -> states 1,2,3,4; icw3=04, icw4=03.
// T4 READY ops: A0=1 8'hF0 -> imr=F0; A0=0 8'h20 -> ocw2_cmd=20 with ocw2_valid high 1 clk;
//    A0=0 8'h0B -> read_select=2'b11; A0=0 8'h68 -> special_mask=1; A0=0 8'h0C -> poll_cmd 1 clk.
// T5 re-init: in READY with imr=F0, write A0=0 8'h13 -> imr=00, special_mask=0, read_select=10, state=1.
// T6 corner cases: A0=0 8'h20 while in WAIT_ICW2 -> ignored; write_bar low with chip_select_bar high -> no change;
//    reset_bar pulsed low in WAIT_ICW3 -> UNINIT, next A0=1 write ignored.

Source files
------------

// File: rtl/icw_ocw_sequencer.sv
// ICW1..ICW4 initialization sequencer and OCW1..OCW3 command decoder.
// Each CPU write is captured while active and decoded on the clock where it ends.
module icw_ocw_sequencer #(
    parameter logic [7:0] IMR_RESET_VAL = 8'h00,
    parameter logic [7:0] ICW4_NONE_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset_bar,
    input  logic       chip_select_bar,
    input  logic       write_bar,
    input  logic       A0,
    input  logic [7:0] internal_bus,
    output logic [7:0] icw1_reg,
    output logic [7:0] icw2_reg,
    output logic [7:0] icw3_reg,
    output logic [7:0] icw4_reg,
    output logic [7:0] imr,
    output logic [7:0] ocw2_cmd,
    output logic       ocw2_valid,
    output logic       poll_cmd,
    output logic [1:0] read_select,
    output logic       special_mask,
    output logic       init_done,
    output logic [2:0] init_state
);

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    state_t     state_reg;
    logic       wr_active;
    logic       wr_q_reg;
    logic       wa0_reg;
    logic [7:0] wdata_reg;
    logic       commit;
    logic       is_icw1;

    assign wr_active = ~chip_select_bar & ~write_bar;
    // A write takes effect on the first clock that sees it finished.
    assign commit    = wr_q_reg & ~wr_active;
    assign is_icw1   = commit & ~wa0_reg & wdata_reg[4];

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            wr_q_reg  <= 1'b0;
            wa0_reg   <= 1'b0;
            wdata_reg <= 8'h00;
        end else begin
            wr_q_reg <= wr_active;
            if (wr_active) begin
                wdata_reg <= internal_bus;
                wa0_reg   <= A0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state_reg    <= UNINIT;
            icw1_reg     <= 8'h00;
            icw2_reg     <= 8'h00;
            icw3_reg     <= 8'h00;
            icw4_reg     <= 8'h00;
            imr          <= IMR_RESET_VAL;
            ocw2_cmd     <= 8'h00;
            ocw2_valid   <= 1'b0;
            poll_cmd     <= 1'b0;
            read_select  <= 2'b10;
            special_mask <= 1'b0;
        end else begin
            ocw2_valid <= 1'b0;
            poll_cmd   <= 1'b0;
            if (is_icw1) begin
                icw1_reg     <= wdata_reg;
                imr          <= 8'h00;
                special_mask <= 1'b0;
                read_select  <= 2'b10;
                if (!wdata_reg[0])
                    icw4_reg <= ICW4_NONE_VAL;
                state_reg    <= WAIT_ICW2;
            end else begin
                case (state_reg)
                    UNINIT: ;
                    WAIT_ICW2: begin
                        if (commit && wa0_reg) begin
                            icw2_reg <= wdata_reg;
                            if (!icw1_reg[1])
                                state_reg <= WAIT_ICW3;
                            else if (icw1_reg[0])
                                state_reg <= WAIT_ICW4;
                            else
                                state_reg <= READY;
                        end
                    end
                    WAIT_ICW3: begin
                        if (commit && wa0_reg) begin
                            icw3_reg  <= wdata_reg;
                            state_reg <= icw1_reg[0] ? WAIT_ICW4 : READY;
                        end
                    end
                    WAIT_ICW4: begin
                        if (commit && wa0_reg) begin
                            icw4_reg  <= wdata_reg;
                            state_reg <= READY;
                        end
                    end
                    READY: begin
                        if (commit) begin
                            if (wa0_reg) begin
                                imr <= wdata_reg;
                            end else if (!wdata_reg[3]) begin
                                ocw2_cmd   <= wdata_reg;
                                ocw2_valid <= 1'b1;
                            end else begin
                                // OCW3 fields only change when their enable bit is set.
                                if (wdata_reg[1])
                                    read_select <= {1'b1, wdata_reg[0]};
                                if (wdata_reg[6])
                                    special_mask <= wdata_reg[5];
                                if (wdata_reg[2])
                                    poll_cmd <= 1'b1;
                            end
                        end
                    end
                    default: state_reg <= UNINIT;
                endcase
            end
        end
    end

    assign init_done  = (state_reg == READY);
    assign init_state = state_reg;

endmodule

// File: tb/tb_icw_ocw_sequencer.sv
// Directed bench for icw_ocw_sequencer: init sequences, READY commands, corner cases.
module tb_icw_ocw_sequencer;

    logic       clk = 1'b0;
    logic       reset_bar;
    logic       chip_select_bar;
    logic       write_bar;
    logic       a0_drv;
    logic [7:0] bus_drv;
    logic [7:0] icw1_reg, icw2_reg, icw3_reg, icw4_reg, imr, ocw2_cmd;
    logic       ocw2_valid, poll_cmd, special_mask, init_done;
    logic [1:0] read_select;
    logic [2:0] init_state;

    int n_cmp = 0;
    int n_err = 0;

    icw_ocw_sequencer dut (
        .clk             (clk),
        .reset_bar       (reset_bar),
        .chip_select_bar (chip_select_bar),
        .write_bar       (write_bar),
        .A0              (a0_drv),
        .internal_bus    (bus_drv),
        .icw1_reg        (icw1_reg),
        .icw2_reg        (icw2_reg),
        .icw3_reg        (icw3_reg),
        .icw4_reg        (icw4_reg),
        .imr             (imr),
        .ocw2_cmd        (ocw2_cmd),
        .ocw2_valid      (ocw2_valid),
        .poll_cmd        (poll_cmd),
        .read_select     (read_select),
        .special_mask    (special_mask),
        .init_done       (init_done),
        .init_state      (init_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // One write cycle; returns #1 after the commit edge.
    task automatic cpu_write(input logic a0, input logic [7:0] d);
        @(negedge clk);
        chip_select_bar = 1'b0;
        write_bar       = 1'b0;
        a0_drv          = a0;
        bus_drv         = d;
        @(negedge clk);
        chip_select_bar = 1'b1;
        write_bar       = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_bar = 1'b0;
        chip_select_bar = 1'b1;
        write_bar = 1'b1;
        a0_drv = 1'b0;
        bus_drv = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        // T1 reset
        check_eq("t1_state", 32'(init_state), 32'd0);
        check_eq("t1_imr", 32'(imr), 32'h00);
        check_eq("t1_rsel", 32'(read_select), 32'd2);
        check_eq("t1_done", 32'(init_done), 32'd0);
        check_eq("t1_pulses", 32'({ocw2_valid, poll_cmd}), 32'd0);
        @(negedge clk);
        reset_bar = 1'b1;

        // T2 single, no ICW4
        cpu_write(1'b0, 8'h12);
        check_eq("t2_icw1", 32'(icw1_reg), 32'h12);
        check_eq("t2_state1", 32'(init_state), 32'd1);
        cpu_write(1'b1, 8'h40);
        check_eq("t2_icw2", 32'(icw2_reg), 32'h40);
        check_eq("t2_icw4", 32'(icw4_reg), 32'h00);
        check_eq("t2_state", 32'(init_state), 32'd4);
        check_eq("t2_done", 32'(init_done), 32'd1);

        // T3 cascade + ICW4
        cpu_write(1'b0, 8'h11);
        check_eq("t3_state1", 32'(init_state), 32'd1);
        cpu_write(1'b1, 8'h08);
        check_eq("t3_icw2", 32'(icw2_reg), 32'h08);
        check_eq("t3_state2", 32'(init_state), 32'd2);
        cpu_write(1'b1, 8'h04);
        check_eq("t3_icw3", 32'(icw3_reg), 32'h04);
        check_eq("t3_state3", 32'(init_state), 32'd3);
        cpu_write(1'b1, 8'h03);
        check_eq("t3_icw4", 32'(icw4_reg), 32'h03);
        check_eq("t3_state4", 32'(init_state), 32'd4);

        // T4 READY operations
        cpu_write(1'b1, 8'hF0);
        check_eq("t4_imr", 32'(imr), 32'hF0);
        cpu_write(1'b0, 8'h20);
        check_eq("t4_ocw2", 32'(ocw2_cmd), 32'h20);
        check_eq("t4_ocw2_valid", 32'(ocw2_valid), 32'd1);
        check_eq("t4_poll_quiet", 32'(poll_cmd), 32'd0);
        next_cycle();
        check_eq("t4_ocw2_valid_drop", 32'(ocw2_valid), 32'd0);
        cpu_write(1'b0, 8'h0B);
        check_eq("t4_rsel_isr", 32'(read_select), 32'd3);
        check_eq("t4_ocw2_kept", 32'(ocw2_cmd), 32'h20);
        check_eq("t4_no_pulse", 32'({ocw2_valid, poll_cmd}), 32'd0);
        cpu_write(1'b0, 8'h68);
        check_eq("t4_smm", 32'(special_mask), 32'd1);
        check_eq("t4_rsel_kept", 32'(read_select), 32'd3);
        cpu_write(1'b0, 8'h0C);
        check_eq("t4_poll", 32'(poll_cmd), 32'd1);
        check_eq("t4_poll_no_ocw2", 32'(ocw2_valid), 32'd0);
        next_cycle();
        check_eq("t4_poll_drop", 32'(poll_cmd), 32'd0);

        // T5 re-init from READY (IC4=1 keeps icw4)
        cpu_write(1'b0, 8'h13);
        check_eq("t5_imr", 32'(imr), 32'h00);
        check_eq("t5_smm", 32'(special_mask), 32'd0);
        check_eq("t5_rsel", 32'(read_select), 32'd2);
        check_eq("t5_state", 32'(init_state), 32'd1);
        check_eq("t5_done", 32'(init_done), 32'd0);
        check_eq("t5_icw4_kept", 32'(icw4_reg), 32'h03);

        // T6 corner cases
        cpu_write(1'b0, 8'h20);
        check_eq("t6_ocw2_ignored_state", 32'(init_state), 32'd1);
        check_eq("t6_ocw2_ignored_valid", 32'(ocw2_valid), 32'd0);
        cpu_write(1'b0, 8'h11);
        check_eq("t6_reinit_state", 32'(init_state), 32'd1);
        @(negedge clk);
        chip_select_bar = 1'b1;
        write_bar = 1'b0;
        a0_drv = 1'b1;
        bus_drv = 8'h99;
        @(negedge clk);
        write_bar = 1'b1;
        repeat (2) next_cycle();
        check_eq("t6_nocs_icw2", 32'(icw2_reg), 32'h08);
        check_eq("t6_nocs_state", 32'(init_state), 32'd1);
        cpu_write(1'b1, 8'h22);
        check_eq("t6_icw2", 32'(icw2_reg), 32'h22);
        check_eq("t6_state3", 32'(init_state), 32'd2);
        @(negedge clk);
        reset_bar = 1'b0;
        #2;
        check_eq("t6_async_state", 32'(init_state), 32'd0);
        check_eq("t6_async_icw2", 32'(icw2_reg), 32'h00);
        check_eq("t6_async_rsel", 32'(read_select), 32'd2);
        @(negedge clk);
        reset_bar = 1'b1;
        cpu_write(1'b1, 8'h77);
        check_eq("t6_post_rst_state", 32'(init_state), 32'd0);
        check_eq("t6_post_rst_icw2", 32'(icw2_reg), 32'h00);
        check_eq("t6_post_rst_icw3", 32'(icw3_reg), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
